// File: rtl/qcode_pkg.sv
// Shared constants and FSM state encoding for the DCQ (decimal-coded quaternary) blocks.
// DCQ words are used by the ALU, this decoder and a future encoder.
package qcode_pkg;

    localparam int DEC_BASE     = 10;
    localparam int RADIX        = 4;
    localparam int MAX_DIGIT    = 3;
    localparam int CARRY_WEIGHT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/qcode_div10.sv
// Iterative divide-by-ten using repeated subtraction.
// After start, one subtraction per cycle; done is high once remainder < 10.
module qcode_div10 #(
    parameter int CODE_W = 7,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CODE_W-1:0] dividend,
    output logic              done,
    output logic [CNT_W-1:0]  quotient,
    output logic [CODE_W-1:0] remainder
);
    import qcode_pkg::*;

    logic [CODE_W-1:0] r_rem;
    logic [CNT_W-1:0]  r_quo;
    logic              w_ge;

    assign w_ge = (r_rem >= CODE_W'(DEC_BASE));

    // Once the remainder drops below ten the registers stop changing on their own,
    // so no separate enable is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
        end else if (start) begin
            r_rem <= dividend;
            r_quo <= '0;
        end else if (w_ge) begin
            r_rem <= r_rem - CODE_W'(DEC_BASE);
            r_quo <= r_quo + 1'b1;
        end
    end

    assign done      = ~w_ge;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/qcode_decoder.sv
// Sequential DCQ-to-binary decoder: {carry, tens*10+units} -> carry*16 + tens*4 + units.
// Illegal digits (>3) decode to zero with out_err set.
//
// state | meaning
// IDLE  | ready for a new word
// DIV   | divider splitting the code into tens and units
// CHECK | digit range check, result registered
// HOLD  | result held until out_ready
module qcode_decoder #(
    parameter int CODE_W = 7,
    parameter int BIN_W  = 5,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  out_bin,
    output logic              out_err,
    output logic              busy
);
    import qcode_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic              r_carry;
    logic              r_out_valid;
    logic              r_out_err;
    logic [BIN_W-1:0]  r_out_bin;
    logic              w_start;
    logic              w_load;
    logic              w_release;
    logic              w_done;
    logic              w_err;
    logic [CNT_W-1:0]  w_quo;
    logic [CODE_W-1:0] w_rem;

    qcode_div10 #(
        .CODE_W (CODE_W),
        .CNT_W  (CNT_W)
    ) u_div10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_start),
        .dividend  (in_code),
        .done      (w_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign w_err = (w_quo > CNT_W'(MAX_DIGIT)) | (w_rem > CODE_W'(MAX_DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_load    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_start = 1'b1;
                    w_next  = DIV;
                end
            end
            DIV: begin
                if (w_done) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_load = 1'b1;
                w_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Legal digits are 2 bits wide, so concatenation is the binary value directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_bin   <= '0;
        end else begin
            if (w_start) begin
                r_carry <= in_carry;
            end
            if (w_load) begin
                r_out_bin   <= w_err ? '0 : BIN_W'({r_carry, w_quo[1:0], w_rem[1:0]});
                r_out_err   <= w_err;
                r_out_valid <= 1'b1;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_qcode_decoder.sv
// Self-checking bench for qcode_decoder: directed corner words plus randomized words
// compared against a divide/modulo reference of the DCQ decoding rule.
module tb_qcode_decoder;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [6:0] in_code   = '0;
    logic       in_carry  = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_bin;
    logic       out_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    qcode_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_err(input int code);
        return ((code / 10) > 3 || (code % 10) > 3) ? 1 : 0;
    endfunction

    function automatic int ref_bin(input int code, input int carry);
        if (ref_err(code) != 0) return 0;
        return carry * 16 + (code / 10) * 4 + (code % 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold = cycles with out_ready low after out_valid rises; noisy = in_valid/in_code toggled while busy
    task automatic run_word(input int code, input int carry, input int hold, input bit noisy);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", int'(in_ready), 1);
        if (!in_ready) return;
        in_code   = 7'(code);
        in_carry  = 1'(carry);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        chk("busy_after_accept", int'(busy), 1);
        in_valid = noisy;
        in_code  = 7'($urandom);
        in_carry = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
            if (noisy) begin
                in_code  = 7'($urandom);
                in_carry = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("latency", n, code / 10 + 2);
        chk("out_bin", int'(out_bin), ref_bin(code, carry));
        chk("out_err", int'(out_err), ref_err(code));
        chk("ready_in_hold", int'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_bin", int'(out_bin), ref_bin(code, carry));
        end
        out_ready = 1'b1;
        tick();
        chk("valid_drop", int'(out_valid), 0);
        chk("ready_back", int'(in_ready), 1);
        chk("busy_clear", int'(busy), 0);
        out_ready = 1'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_bin", int'(out_bin), 0);
        chk("rst_err", int'(out_err), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", int'(in_ready), 1);

        run_word(23, 0, 0, 1'b0);
        run_word(33, 1, 0, 1'b0);
        run_word(0, 0, 0, 1'b0);
        run_word(14, 0, 1, 1'b0);
        run_word(40, 0, 0, 1'b0);
        run_word(127, 0, 2, 1'b0);
        run_word(12, 0, 6, 1'b0);
        run_word(30, 1, 0, 1'b1);
        run_word(1, 0, 0, 1'b0);
        run_word(2, 0, 0, 1'b0);
        run_word(3, 0, 0, 1'b0);

        // async reset in the middle of a long division
        in_code  = 7'd127;
        in_carry = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("busy_mid_div", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_div_busy", int'(busy), 0);
        chk("rst_div_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_word(21, 1, 0, 1'b0);

        // async reset while a result is held
        out_ready = 1'b0;
        in_code   = 7'd33;
        in_carry  = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("pre_rst_bin", int'(out_bin), 31);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", int'(out_valid), 0);
        chk("rst_hold_bin", int'(out_bin), 0);
        chk("rst_hold_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 40; k++) begin
            run_word(int'($urandom_range(0, 127)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
